// File: rtl/multi_button_debouncer.sv
// ============================================================================
//  Module   : multi_button_debouncer
//  Purpose  : Debounces NUM_CH push buttons with per-channel saturating
//             up/down integrators and hysteresis. Produces debounced levels,
//             press/release pulses, and offers latched press events to the
//             UART transmit path over a valid/ready request interface that
//             carries the channel index (lowest pending channel first).
//  Ports    : clk           - system clock, rising edge
//             rst_n         - asynchronous active-low reset
//             btn_in        - raw asynchronous button inputs [NUM_CH]
//             btn_level     - debounced level per channel
//             press_pulse   - 1-cycle pulse on debounced rising level
//             release_pulse - 1-cycle pulse on debounced falling level
//             overrun       - 1-cycle pulse when an event hits a pending channel
//             tx_valid      - transmit request pending
//             tx_ch         - channel index of the current request
//             tx_ready      - consumer accepts the request
//  Options  : DEBOUNCE_AUTOREPEAT_EN - adds per-channel auto-repeat timers
//             (parameters REPEAT_DELAY / REPEAT_PERIOD).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_button_debouncer #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 20,
  parameter int THRESH_ON  = 100000,
  parameter int THRESH_OFF = 50000,
  parameter int CNT_MAX    = 120000,
  parameter int CH_W       = 2
`ifdef DEBOUNCE_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse,
  output logic [NUM_CH-1:0] overrun,
  output logic              tx_valid,
  output logic [CH_W-1:0]   tx_ch,
  input  logic              tx_ready
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] C_TH_ON   = CNT_W'(THRESH_ON);
  localparam logic [CNT_W-1:0] C_TH_OFF  = CNT_W'(THRESH_OFF);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  logic [NUM_CH-1:0] sync1_q, sync2_q;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] level_q, level_d;
  logic [NUM_CH-1:0] press_q, press_d;
  logic [NUM_CH-1:0] release_q, release_d;
  logic [NUM_CH-1:0] overrun_q, overrun_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] rep_d;
  logic [NUM_CH-1:0] event_d;
  logic [NUM_CH-1:0] clr_d;
  logic              handshake;
  state_t            state_q, state_d;
  logic [CH_W-1:0]   tx_ch_q, tx_ch_d;

  // Lowest set bit index; scanning downward lets the lowest index win.
  function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] v);
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest = CH_W'(i);
    end
  endfunction

  // Integrator and level hysteresis per channel.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] && (cnt_q[i] < C_CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!sync2_q[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
      if (!level_q[i] && (cnt_q[i] >= C_TH_ON)) begin
        level_d[i] = 1'b1;
        press_d[i] = 1'b1;
      end else if (level_q[i] && (cnt_q[i] <= C_TH_OFF)) begin
        level_d[i]   = 1'b0;
        release_d[i] = 1'b1;
      end
    end
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam logic [31:0] C_RPT_DLY    = 32'(REPEAT_DELAY);
  // Reloading to DELAY-PERIOD+1 makes the next match land PERIOD edges later.
  localparam logic [31:0] C_RPT_RELOAD = 32'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  logic [31:0] rpt_q [NUM_CH];
  logic [31:0] rpt_d [NUM_CH];

  always_comb begin
    rep_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rpt_d[i] = '0;
      if (press_d[i]) begin
        rpt_d[i] = '0;
      end else if (level_q[i] && !release_d[i]) begin
        if (rpt_q[i] == C_RPT_DLY) begin
          rep_d[i] = 1'b1;
          rpt_d[i] = C_RPT_RELOAD;
        end else begin
          rpt_d[i] = rpt_q[i] + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) rpt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) rpt_q[i] <= rpt_d[i];
    end
  end
`else
  assign rep_d = '0;
`endif

  // Pending bits: set wins over a same-edge clear; an event on a channel that
  // stays pending is dropped and flagged as overrun.
  assign handshake = (state_q == ST_OFFER) && tx_ready;
  assign event_d   = press_d | rep_d;

  always_comb begin
    clr_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      clr_d[i] = handshake && (tx_ch_q == CH_W'(i));
    end
    pending_d = (pending_q & ~clr_d) | event_d;
    overrun_d = event_d & pending_q & ~clr_d;
  end

  // Request FSM. On a handshake the next channel comes from the post-update
  // pending vector so back-to-back requests need no idle cycle.
  always_comb begin
    state_d = state_q;
    tx_ch_d = tx_ch_q;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          state_d = ST_OFFER;
          tx_ch_d = lowest(pending_q);
        end
      end
      ST_OFFER: begin
        if (tx_ready) begin
          if (|pending_d) begin
            tx_ch_d = lowest(pending_d);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      overrun_q <= '0;
      pending_q <= '0;
      state_q   <= ST_IDLE;
      tx_ch_q   <= '0;
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      overrun_q <= overrun_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      tx_ch_q   <= tx_ch_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign overrun       = overrun_q;
  assign tx_valid      = (state_q == ST_OFFER);
  assign tx_ch         = tx_ch_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_button_debouncer.sv
// ============================================================================
//  Module   : tb_multi_button_debouncer
//  Purpose  : Self-checking bench for multi_button_debouncer with
//             THRESH_ON=8, THRESH_OFF=3, CNT_MAX=10, NUM_CH=4.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_button_debouncer;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_in;
  logic [3:0] btn_level;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] overrun;
  logic       tx_valid;
  logic [1:0] tx_ch;
  logic       tx_ready;

  int total_cnt;
  int pass_cnt;

  multi_button_debouncer #(
    .NUM_CH     (4),
    .CNT_W      (20),
    .THRESH_ON  (8),
    .THRESH_OFF (3),
    .CNT_MAX    (10),
    .CH_W       (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .overrun       (overrun),
    .tx_valid      (tx_valid),
    .tx_ch         (tx_ch),
    .tx_ready      (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] btn;
    logic       rdy;
    int         cyc;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic       vld;
    logic [1:0] ch;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       seen;
    int         ovr_cnt;
    total_cnt = 0;
    pass_cnt  = 0;

    // Clean press of ch0 (level on edge 11, request on edge 12), then a
    // release from saturation (level falls 10 edges after the drop).
    vecs[0] = '{"press_pre",  4'b0001, 1'b0, 10, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[1] = '{"press_e11",  4'b0001, 1'b0, 1,  4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0};
    vecs[2] = '{"press_e12",  4'b0001, 1'b0, 1,  4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd0};
    vecs[3] = '{"accept",     4'b0001, 1'b1, 1,  4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[4] = '{"rel_pre",    4'b0000, 1'b0, 9,  4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[5] = '{"rel_e10",    4'b0000, 1'b0, 1,  4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0};
    vecs[6] = '{"rel_after",  4'b0000, 1'b0, 1,  4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};

    rst_n    = 1'b0;
    btn_in   = '0;
    tx_ready = 1'b0;
    step();
    step();
    chk("rst_level", {28'd0, btn_level}, 32'd0);
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_ch",    {30'd0, tx_ch}, 32'd0);
    rst_n = 1'b1;
    step();

    foreach (vecs[k]) begin
      btn_in   = vecs[k].btn;
      tx_ready = vecs[k].rdy;
      repeat (vecs[k].cyc) step();
      chk({vecs[k].name, "_level"}, {28'd0, btn_level}, {28'd0, vecs[k].lvl});
      chk({vecs[k].name, "_press"}, {28'd0, press_pulse}, {28'd0, vecs[k].prs});
      chk({vecs[k].name, "_rel"},   {28'd0, release_pulse}, {28'd0, vecs[k].rel});
      chk({vecs[k].name, "_valid"}, {31'd0, tx_valid}, {31'd0, vecs[k].vld});
      if (vecs[k].vld) chk({vecs[k].name, "_ch"}, {30'd0, tx_ch}, {30'd0, vecs[k].ch});
    end

    // Bounce on ch1: toggle every 3 cycles for 60 cycles.
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      btn_in[1] = ~btn_in[1];
      repeat (3) begin
        step();
        seen = seen | btn_level[1] | press_pulse[1] | tx_valid;
      end
    end
    chk("bounce_quiet", {31'd0, seen}, 32'd0);
    btn_in = '0;
    repeat (20) step();

    // Arbitration: ch0 and ch2 pressed together.
    btn_in = 4'b0101;
    repeat (11) step();
    chk("arb_press", {28'd0, press_pulse}, 32'h5);
    step();
    chk("arb_valid0", {31'd0, tx_valid}, 32'd1);
    chk("arb_ch0",    {30'd0, tx_ch}, 32'd0);
    seen = 1'b0;
    repeat (5) begin
      step();
      seen = seen | (tx_ch != 2'd0) | ~tx_valid;
    end
    chk("arb_hold", {31'd0, seen}, 32'd0);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("arb_valid1", {31'd0, tx_valid}, 32'd1);
    chk("arb_ch2",    {30'd0, tx_ch}, 32'd2);
    step();
    chk("arb_ch2_hold", {30'd0, tx_ch}, 32'd2);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("arb_done", {31'd0, tx_valid}, 32'd0);
    btn_in = '0;
    seen = 1'b0;
    repeat (25) begin
      step();
      seen = seen | tx_valid;
    end
    chk("arb_release_noreq", {31'd0, seen}, 32'd0);

    // Overrun: ch1 pressed, released, pressed again while still pending.
    btn_in = 4'b0010;
    repeat (11) step();
    chk("ovr_first_press", {28'd0, press_pulse}, 32'h2);
    chk("ovr_first_none",  {28'd0, overrun}, 32'd0);
    step();
    chk("ovr_valid", {31'd0, tx_valid}, 32'd1);
    step();
    btn_in = 4'b0000;
    repeat (10) step();
    chk("ovr_released", {28'd0, release_pulse}, 32'h2);
    repeat (15) step();
    btn_in  = 4'b0010;
    ovr_cnt = 0;
    repeat (14) begin
      step();
      if (overrun[1]) ovr_cnt++;
    end
    chk("ovr_once",    ovr_cnt, 32'd1);
    chk("ovr_pending", {31'd0, tx_valid}, 32'd1);
    chk("ovr_ch",      {30'd0, tx_ch}, 32'd1);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    seen = tx_valid;
    repeat (5) begin
      step();
      seen = seen | tx_valid;
    end
    chk("ovr_single_hs", {31'd0, seen}, 32'd0);
    btn_in = '0;
    repeat (25) step();

    // Reset mid-operation.
    btn_in = 4'b1000;
    repeat (8) step();
    btn_in = 4'b1001;
    repeat (4) step();
    chk("rstm_valid_before", {31'd0, tx_valid}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rstm_level", {28'd0, btn_level}, 32'd0);
    chk("rstm_valid", {31'd0, tx_valid}, 32'd0);
    chk("rstm_ch",    {30'd0, tx_ch}, 32'd0);
    chk("rstm_pulses", {20'd0, press_pulse, release_pulse, overrun}, 32'd0);
    btn_in = '0;
    #2;
    rst_n = 1'b1;
    step();
    btn_in = 4'b0001;
    repeat (4) step();
    btn_in = 4'b0000;
    seen = 1'b0;
    repeat (20) begin
      step();
      seen = seen | (|btn_level) | (|press_pulse) | tx_valid;
    end
    chk("rstm_short_pulse", {31'd0, seen}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_button_debouncer.md
Name: multi_button_debouncer

Overview:
Debounces NUM_CH push-button inputs in one clock domain. Each channel uses a saturating up/down integrator with hysteresis and produces a debounced level plus press/release pulses. Press events are latched per channel and offered to the UART transmit path through a valid/ready request interface that carries the channel index. This block replaces single-button debouncers in front of the transmitter.

Parameters:
NUM_CH, 4, number of button channels (1..16)
CNT_W, 20, integrator counter width per channel
THRESH_ON, 100000, counter value at or above which the level goes high
THRESH_OFF, 50000, counter value at or below which the level goes low; must be < THRESH_ON
CNT_MAX, 120000, counter saturation value; THRESH_ON <= CNT_MAX <= 2^CNT_W-1
CH_W, 2, width of tx_ch; must be >= clog2(NUM_CH)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
btn_in  input  NUM_CH  raw asynchronous button inputs
btn_level  output  NUM_CH  debounced level per channel
press_pulse  output  NUM_CH  one-cycle pulse on debounced rising level
release_pulse  output  NUM_CH  one-cycle pulse on debounced falling level
overrun  output  NUM_CH  one-cycle pulse when a press hits an already-pending channel
tx_valid  output  1  transmit request pending
tx_ch  output  CH_W  channel index of the current request
tx_ready  input  1  consumer accepts the request

Behaviour:
- Reset: asynchronous on rst_n low. All synchronisers, counters, btn_level, pulses, overrun, pending bits, tx_valid and tx_ch are cleared to 0 immediately. Release of rst_n takes effect on the next clk edge.
- Synchroniser: two flops per channel. Only the second flop (sync) feeds the logic.
- Counter, per channel:
  - sync=1 and cnt<CNT_MAX: cnt+1.
  - sync=0 and cnt>0: cnt-1.
  - Otherwise hold. The counter never wraps.
- Level, registered from the current cnt:
  - level=0 and cnt>=THRESH_ON: level becomes 1.
  - level=1 and cnt<=THRESH_OFF: level becomes 0.
- Latency: with btn_in held from cnt=0, btn_level rises THRESH_ON+3 edges after the btn_in change. With btn_in dropped from cnt=CNT_MAX, btn_level falls CNT_MAX-THRESH_OFF+3 edges after the change.
- press_pulse / release_pulse: asserted high on the same edge the level changes, for exactly one cycle.
- Pending bit, per channel:
  - Set on a press event.
  - Cleared on a handshake (tx_valid & tx_ready) where tx_ch equals that channel.
  - Set and clear on the same edge: set wins, so the channel stays pending.
  - Press while already pending and not being cleared that edge: pending unchanged, overrun pulses for 1 cycle, and the event is dropped.
- Request FSM, states IDLE and OFFER:
  - IDLE (tx_valid=0): if any pending bit is set, load tx_ch with the lowest-indexed pending channel and go to OFFER.
  - OFFER: tx_valid=1 and tx_ch is frozen until a handshake.
  - On a handshake, re-select the lowest-indexed pending channel from the post-update pending vector. If one exists, stay in OFFER (back-to-back, no idle cycle); else go to IDLE.
  - First tx_valid appears 1 edge after the press edge.
- tx_valid never deasserts without a handshake, except on reset.

Optional Feature:
DEBOUNCE_AUTOREPEAT_EN
- Defined:
  - Adds parameters REPEAT_DELAY (default 50000000) and REPEAT_PERIOD (default 10000000), plus one 32-bit repeat timer per channel.
  - The timer clears on a press event and counts while btn_level=1.
  - At REPEAT_DELAY, and then every REPEAT_PERIOD, a repeat event sets pending with the same overrun rules as a press. press_pulse is not asserted for repeats.
  - The timer clears and stops when the level falls.
- Undefined: no timers, no repeat events; the repeat parameters are absent.

Test Plan:
(Test parameters: THRESH_ON=8, THRESH_OFF=3, CNT_MAX=10, NUM_CH=4.)
1. Clean press: btn_in[0]=1 held from idle -> btn_level[0] rises on edge 11, press_pulse[0] high exactly 1 cycle, tx_valid=1 with tx_ch=0 on edge 12.
2. Bounce: btn_in[1] toggled every 3 cycles for 60 cycles -> cnt never reaches 8; btn_level, press_pulse and tx_valid stay 0.
3. Hysteresis release: ch0 saturated at cnt=10, btn_in[0] dropped -> btn_level[0] falls on edge 10, release_pulse[0] one cycle, no new request.
4. Arbitration: ch2 and ch0 pressed the same cycle, tx_ready=0 -> tx_ch=0 held stable. One-cycle tx_ready -> tx_ch=2 next cycle with tx_valid still 1. Second ready -> tx_valid=0.
5. Overrun: ch1 pressed, released, pressed again with tx_ready=0 -> overrun[1] pulses once and exactly one handshake with tx_ch=1 follows.
6. Reset mid-operation: rst_n low between clock edges while tx_valid=1 and counters mid-count -> all outputs 0 immediately. After release, a 4-cycle btn pulse produces no level change.
